// File: rtl/collapse_key_assembler_if.sv
// collapse_key_assembler_if
//   Groups every signal of the key assembler except clk and reset:
//   - the control inputs (start, abort),
//   - the bank of read-once collapse cells,
//   - the valid/ready key handshake toward the key-exchange consumer,
//   - the status outputs.
//
//   Modports:
//     master : the assembler. It drives frag_read, key_out, key_valid, busy,
//              error and err_index.
//     slave  : the environment. It drives start, abort, the cell outputs and
//              key_ready.
//
//   NUM_FRAGS must match the value given to collapse_key_assembler.
interface collapse_key_assembler_if #(
  parameter int NUM_FRAGS = 4
);
  localparam int IDX_W = $clog2(NUM_FRAGS);

  // Control
  logic                   start;
  logic                   abort;

  // Cell bank: one-hot read strobes out, combinational cell outputs back
  logic [NUM_FRAGS-1:0]   frag_read;
  logic [8*NUM_FRAGS-1:0] frag_data;
  logic [NUM_FRAGS-1:0]   frag_oe;
  logic [NUM_FRAGS-1:0]   frag_pad;

  // Key handshake
  logic [8*NUM_FRAGS-1:0] key_out;
  logic                   key_valid;
  logic                   key_ready;

  // Status
  logic                   busy;
  logic                   error;
  logic [IDX_W-1:0]       err_index;

  modport master (
    input  start, abort, frag_data, frag_oe, frag_pad, key_ready,
    output frag_read, key_out, key_valid, busy, error, err_index
  );

  modport slave (
    output start, abort, frag_data, frag_oe, frag_pad, key_ready,
    input  frag_read, key_out, key_valid, busy, error, err_index
  );
endinterface

// File: rtl/collapse_key_assembler.sv
// collapse_key_assembler
//   Reads a bank of NUM_FRAGS single-byte, read-once collapse cells in order.
//   Each cell gets exactly one one-hot strobe. Between strobes the block waits
//   READ_GAP idle cycles. When all bytes are in, it presents the assembled key
//   on a valid/ready handshake.
//
//   The key register is zeroised in each of these cases, so no secret
//   lingers here:
//   - on start,
//   - on a failed read,
//   - on abort,
//   - after the key has been delivered.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high reset
//     bus    : collapse_key_assembler_if.master. It carries:
//              - start / abort control,
//              - frag_read / frag_data / frag_oe / frag_pad to the cells,
//              - key_out / key_valid / key_ready toward the consumer,
//              - busy / error / err_index status.
module collapse_key_assembler #(
  parameter  int NUM_FRAGS = 4,
  parameter  int READ_GAP  = 1,
  localparam int IDX_W     = $clog2(NUM_FRAGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  collapse_key_assembler_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    GAP,
    HOLD,
    FAIL
  } state_t;

  localparam int                GAP_W    = (READ_GAP > 1) ? $clog2(READ_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((READ_GAP > 0) ? READ_GAP - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_FRAGS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [8*NUM_FRAGS-1:0] key_reg;
  logic [NUM_FRAGS-1:0]   frag_read_q;
  logic                   key_valid_q;
  logic                   error_q;
  logic [IDX_W-1:0]       err_index_q;

  // Cell outputs are combinational during the strobe cycle. They are judged
  // and captured on the edge that ends that cycle.
  logic                   frag_good;
  logic [7:0]             frag_byte;

  // NOTE: both signals are assigned on every path through the block, so no
  // latch can be inferred.
  always_comb begin
    frag_good = bus.frag_oe[idx] & bus.frag_pad[idx];
    frag_byte = bus.frag_data[8*idx +: 8];
  end

  // NOTE: the key register is reset like any other state. It holds secret
  // material, so it must never come up holding an undefined value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      key_reg     <= '0;
      frag_read_q <= '0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else if (bus.abort) begin
      // Abort overrides everything, including start in IDLE.
      // It drops the strobe, wipes the key and clears error without raising one.
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the pre-edge values of the others.
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      key_reg     <= '0;
      frag_read_q <= '0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            error_q     <= 1'b0;
            err_index_q <= '0;
            key_reg     <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            frag_read_q <= NUM_FRAGS'(1);
            state       <= READ;
          end
        end

        READ: begin
          frag_read_q <= '0;
          if (frag_good) begin
            key_reg[8*idx +: 8] <= frag_byte;
            if (idx == IDX_LAST) begin
              key_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              idx <= idx + 1'b1;
              if (READ_GAP > 0) begin
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                // No gap: strobe the next cell straight away.
                frag_read_q <= NUM_FRAGS'(1) << (idx + 1'b1);
                state       <= READ;
              end
            end
          end else begin
            // The cell was already collapsed, killed or fused.
            // Discard the partial key.
            error_q     <= 1'b1;
            err_index_q <= idx;
            key_reg     <= '0;
            state       <= FAIL;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            frag_read_q <= NUM_FRAGS'(1) << idx;
            state       <= READ;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (bus.key_ready) begin
            key_reg     <= '0;
            key_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        FAIL: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.frag_read = frag_read_q;
  assign bus.key_valid = key_valid_q;
  // The key is gated so that it can only be seen while it is being offered.
  assign bus.key_out   = key_reg & {(8*NUM_FRAGS){key_valid_q}};
  assign bus.busy      = (state != IDLE);
  assign bus.error     = error_q;
  assign bus.err_index = err_index_q;

endmodule

// File: doc/collapse_key_assembler.md
Name: collapse_key_assembler

Overview:
Downstream consumer for a bank of NUM_FRAGS single-byte read-once collapse cells. It sequences one-hot read strobes across the bank and captures each fragment on its single live read. It assembles the full key and hands it to the key-exchange consumer over a valid/ready handshake. Partial keys are zeroised on any failure, abort, or after delivery, so a secret never persists in this stage.

Parameters:
NUM_FRAGS, 4, number of collapse cells / key bytes; must be >= 2
READ_GAP, 1, idle cycles between successive cell reads; 0 allowed
IDX_W, $clog2(NUM_FRAGS), width of the fragment index (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request one key assembly; sampled only in IDLE
abort  input  1  cancel any operation, zeroise, return to IDLE; priority over start
frag_read  output  NUM_FRAGS  one-hot read strobe to cell i (drives the cell's read input)
frag_data  input  8*NUM_FRAGS  concatenated key_fragment buses; cell i at [8*i +: 8]
frag_oe  input  NUM_FRAGS  output_enable from each cell
frag_pad  input  NUM_FRAGS  pad_enable from each cell
key_out  output  8*NUM_FRAGS  assembled key, byte i from cell i; forced 0 unless key_valid
key_valid  output  1  assembled key available
key_ready  input  1  consumer accepts key
busy  output  1  high in any state except IDLE
error  output  1  sticky fail flag; cleared by next accepted start, abort or reset
err_index  output  IDX_W  index of the cell that failed; valid while error=1

Behaviour:
- Reset values: frag_read=0, key_out=0, key_valid=0, busy=0, error=0, err_index=0. Internal key register=0, idx=0, gap counter=0, state=IDLE.
- Reset mid-operation: all of the above values apply immediately (asynchronous). Cells already read stay collapsed; no retry.
- Cell outputs are combinational in the read cycle. Capture happens on the same rising edge that ends the frag_read cycle.
- FSM states: IDLE, READ, GAP, HOLD, FAIL.
- IDLE:
  - start=1 and abort=0: clear error, zeroise the key register, set idx=0, go to READ.
- READ (lasts exactly 1 cycle): frag_read = 1<<idx.
  - Fragment is good if frag_oe[idx] & frag_pad[idx]; store frag_data slice idx into key byte idx.
  - Good and idx==NUM_FRAGS-1: go to HOLD.
  - Good otherwise: idx++. Go to GAP if READ_GAP>0, else READ.
  - Not good (cell already collapsed, killed, or fused): error<=1, err_index<=idx, zeroise the key register, go to FAIL.
- GAP: frag_read=0 for READ_GAP cycles, counted by the gap counter, then go to READ.
- HOLD: key_valid=1, key_out=key register, held stable.
  - key_ready=1 (same cycle or later): handshake completes on that edge. Zeroise the key register, key_valid=0 next cycle, go to IDLE.
  - key_ready before HOLD has no effect.
- FAIL: one cycle with busy=1, then IDLE. error and err_index stay until the next accepted start or an abort.
- abort in any non-IDLE state: on the next edge frag_read=0, zeroise, key_valid=0, go to IDLE. error is cleared; no error is raised.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- frag_read is never asserted outside READ and is never multi-hot. Each cell is strobed at most once per assembly.
- Latency: start sampled at edge E0 gives frag_read[0] in the cycle after E0. key_valid rises NUM_FRAGS + (NUM_FRAGS-1)*READ_GAP edges after E0. Defaults give 7 edges.
- key_out is AND-gated with key_valid. It outputs 0 in every state except HOLD.

Test Plan:
- NUM_FRAGS=4, READ_GAP=1, all four cells armed with 0x11, 0x22, 0x33, 0x44, start pulse -> frag_read goes 0001, 0010, 0100, 1000 on alternate cycles; key_valid 7 edges after start; key_out=0x44332211; key_ready=1 -> key_valid=0 and key_out=0 the next cycle; busy=0.
- Cell 2 pre-collapsed (frag_oe[2]=0), cells 0/1 live -> error=1, err_index=2, key_out=0 throughout, frag_read[3] never asserted, busy falls after FAIL; next start clears error.
- Backpressure: key_ready held 0 for 10 cycles in HOLD -> key_out stable at the assembled value, key_valid=1; no further frag_read pulses.
- abort asserted during the GAP after byte 1 -> next cycle state IDLE, error=0, key_out=0; start asserted while busy earlier had no effect (frag_read sequence not restarted).
- Async reset asserted between READ of cells 1 and 2 -> all outputs zero immediately; after release and a fresh start, cells 0/1 report frag_oe=0, giving error=1, err_index=0.
- READ_GAP=0 variant -> back-to-back one-hot strobes on consecutive cycles; key_valid 4 edges after start.
